xy_packet_injector: RTL



---
 rtl/xy_packet_injector.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/xy_packet_injector.sv
// xy_packet_injector: source-side network interface for the 2D mesh.
// Turns a packet request (destination, body length) plus a payload word
// stream into head/body/tail flits for the local router input port, under
// credit-based flow control (one credit per downstream flit slot).
// Optional feature: define XY_INJ_STATS_EN to add the pkt_cnt/drop_cnt
// statistics outputs; without it the block has no statistics at all.
module xy_packet_injector #(
  parameter int NX      = 4,
  parameter int NY      = 3,
  parameter int Xw      = 2,
  parameter int Yw      = 2,
  parameter int Fw      = 32,
  parameter int MAX_LEN = 15,
  parameter int CREDITS = 4,
  parameter int LENw    = $clog2(MAX_LEN + 1),
  parameter int CRw     = $clog2(CREDITS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Xw-1:0]   current_x,
  input  logic [Yw-1:0]   current_y,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [Xw-1:0]   req_dest_x,
  input  logic [Yw-1:0]   req_dest_y,
  input  logic [LENw-1:0] req_len,
  input  logic            payload_valid,
  output logic            payload_ready,
  input  logic [Fw-1:0]   payload_data,
  output logic            flit_wr,
  output logic            flit_head,
  output logic            flit_tail,
  output logic [Fw-1:0]   flit_data,
  input  logic            credit_in,
  output logic            err
`ifdef XY_INJ_STATS_EN
  ,
  output logic [15:0]     pkt_cnt,
  output logic [7:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t          state_q;
  logic [Xw-1:0]   dest_x_q, src_x_q;
  logic [Yw-1:0]   dest_y_q, src_y_q;
  logic [LENw-1:0] len_q, rem_q;
  logic [CRw-1:0]  cr_q, cr_d;
  logic            cr_ovf;
  logic            flit_wr_q, flit_head_q, flit_tail_q, err_q;
  logic [Fw-1:0]   flit_data_q;

  logic has_credit, send, tail_send, req_illegal, reject;

  assign has_credit  = (cr_q != '0);
  // A flit leaves this cycle: the head in HEAD, or a body word on handshake.
  assign send        = has_credit &&
                       ((state_q == HEAD) || ((state_q == BODY) && payload_valid));
  assign tail_send   = send && (((state_q == HEAD) && (len_q == '0)) ||
                                ((state_q == BODY) && (rem_q == LENw'(1))));
  assign req_illegal = (int'(req_dest_x) >= NX) || (int'(req_dest_y) >= NY) ||
                       (int'(req_len) > MAX_LEN);
  assign reject      = (state_q == IDLE) && req_valid && req_illegal;

  assign req_ready     = (state_q == IDLE);
  assign payload_ready = (state_q == BODY) && has_credit;

  assign flit_wr   = flit_wr_q;
  assign flit_head = flit_head_q;
  assign flit_tail = flit_tail_q;
  assign flit_data = flit_data_q;
  assign err       = err_q;

  // Credit counter next state: a send and a returned credit cancel out;
  // a credit returned while already full saturates and flags an error.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cr_d   = cr_q;
    cr_ovf = 1'b0;
    if (send && !credit_in) begin
      cr_d = cr_q - CRw'(1);
    end else if (credit_in && !send) begin
      if (cr_q == CRw'(CREDITS)) cr_ovf = 1'b1;
      else                       cr_d   = cr_q + CRw'(1);
    end
  end

  // Packet FSM with registered flit outputs, credit counter and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (reset) begin
      state_q     <= IDLE;
      cr_q        <= CRw'(CREDITS);
      rem_q       <= '0;
      len_q       <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      flit_wr_q   <= 1'b0;
      flit_head_q <= 1'b0;
      flit_tail_q <= 1'b0;
      flit_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cr_q      <= cr_d;
      flit_wr_q <= 1'b0;
      err_q     <= reject || cr_ovf;
      unique case (state_q)
        IDLE: begin
          if (req_valid && !req_illegal) begin
            dest_x_q <= req_dest_x;
            dest_y_q <= req_dest_y;
            len_q    <= req_len;
            src_x_q  <= current_x;
            src_y_q  <= current_y;
            state_q  <= HEAD;
          end
        end
        HEAD: begin
          if (send) begin
            flit_wr_q   <= 1'b1;
            flit_head_q <= 1'b1;
            flit_tail_q <= (len_q == '0);
            // Head layout from LSB: dest_x, dest_y, src_x, src_y, len; rest zero.
            flit_data_q <= Fw'({len_q, src_y_q, src_x_q, dest_y_q, dest_x_q});
            rem_q       <= len_q;
            state_q     <= (len_q == '0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (send) begin
            flit_wr_q   <= 1'b1;
            flit_head_q <= 1'b0;
            flit_tail_q <= (rem_q == LENw'(1));
            flit_data_q <= payload_data;
            rem_q       <= rem_q - LENw'(1);
            if (rem_q == LENw'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef XY_INJ_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [7:0]  drop_cnt_q;

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // Statistics: wrapping count of completed packets, saturating count of drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (tail_send) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (reject && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`endif

endmodule
